// File: rtl/simd_dot_accumulator.sv
// Saturating dot-product accumulator behind the dual 9x9 SIMD multiplier.
// Sums a stream of signed terms per vector and emits the result with a sticky overflow flag.
module simd_dot_accumulator #(
    parameter int IN_W      = 36,
    parameter int ACC_W     = 48,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic             accept;
    logic             close;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign in_ready = (state != HOLD) & ~clr;
    assign accept   = in_valid & in_ready;
    assign cnt_nxt  = count + 1'b1;
    assign close    = in_last | (cnt_nxt == CNT_W'(MAX_TERMS));

    // One guard bit: top two bits disagree exactly when the add overflowed.
    always_comb begin
        sum     = {acc[ACC_W-1], acc}
                + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        acc_nxt = sum[ACC_W-1:0];
        ovf_nxt = ovf;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_nxt = sum[ACC_W] ? NEG_MIN : POS_MAX;
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (close) begin
                            out_data     <= acc_nxt;
                            out_count    <= cnt_nxt;
                            out_overflow <= ovf_nxt;
                            out_valid    <= 1'b1;
                            acc          <= '0;
                            count        <= '0;
                            ovf          <= 1'b0;
                            state        <= HOLD;
                        end else begin
                            acc   <= acc_nxt;
                            count <= cnt_nxt;
                            ovf   <= ovf_nxt;
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_dot_accumulator.sv
// Directed bench for simd_dot_accumulator, built narrow (20-bit, 4 terms max)
// so saturation and force-close are reachable with hand-computed vectors.
module tb_simd_dot_accumulator;

    localparam int IN_W  = 20;
    localparam int ACC_W = 20;
    localparam int MAXT  = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    int checks;
    int failures;

    simd_dot_accumulator #(
        .IN_W(IN_W),
        .ACC_W(ACC_W),
        .MAX_TERMS(MAXT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_count(out_count),
        .out_overflow(out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int t [4];
        int n;
        int exp_d;
        int exp_c;
        int exp_o;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input int a, input int b, input int c,
                                input int d, input int n, input int ed,
                                input int ec, input int eo);
        vec_t v;
        v.t[0] = a;
        v.t[1] = b;
        v.t[2] = c;
        v.t[3] = d;
        v.n = n;
        v.exp_d = ed;
        v.exp_c = ec;
        v.exp_o = eo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    task automatic send(input int d, input logic last);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data = IN_W'(d);
        in_last = last;
        while (!in_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck at 0");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
    endtask

    task automatic expect_result(input string name, input int ed,
                                 input int ec, input int eo);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_data"}, sdata(), ed);
        check({name, "_count"}, int'(out_count), ec);
        check({name, "_ovf"}, int'(out_overflow), eo);
        @(posedge clk);
        #1;
        check({name, "_drop"}, int'(out_valid), 0);
        check({name, "_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;

        vecs[0] = mk(100, -40, 7, 0, 3, 67, 3, 0);
        vecs[1] = mk(262144, 262144, 0, 0, 2, 524287, 2, 1);
        vecs[2] = mk(5, 0, 0, 0, 1, 5, 1, 0);
        vecs[3] = mk(-524288, -1, 0, 0, 2, -524288, 2, 1);
        vecs[4] = mk(524287, 10, -20, 0, 3, 524267, 3, 1);
        vecs[5] = mk(-3, -4, -5, 0, 3, -12, 3, 0);
        vecs[6] = mk(1000, -1000, 0, 0, 2, 0, 2, 0);
        vecs[7] = mk(1, 2, 3, 4, 4, 10, 4, 0);

        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", sdata(), 0);
        check("rst_count", int'(out_count), 0);
        check("rst_ovf", int'(out_overflow), 0);
        check("rst_ready", int'(in_ready), 1);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                send(vecs[i].t[j], j == vecs[i].n - 1);
            expect_result($sformatf("vec%0d", i), vecs[i].exp_d,
                          vecs[i].exp_c, vecs[i].exp_o);
        end

        // force-close at MAX_TERMS, remainder forms the next vector
        for (int j = 0; j < 4; j++) send(1, 1'b0);
        expect_result("force", 4, 4, 0);
        send(1, 1'b0);
        send(1, 1'b0);
        check("force_tail_pending", int'(out_valid), 0);
        send(1, 1'b1);
        expect_result("force_tail", 3, 3, 0);

        // output backpressure
        out_ready = 1'b0;
        send(1, 1'b0);
        send(2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", sdata(), 3);
            check("bp_count", int'(out_count), 2);
            check("bp_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_valid_rel", int'(out_valid), 1);
        @(posedge clk);
        #1;
        check("bp_drop", int'(out_valid), 0);
        check("bp_ready_back", int'(in_ready), 1);

        // clr mid-vector discards the partial sum
        send(50, 1'b0);
        send(60, 1'b0);
        clr = 1'b1;
        #1;
        check("clr_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_no_out", int'(out_valid), 0);
        send(9, 1'b1);
        expect_result("clr_vec", 9, 1, 0);

        // async reset mid-vector
        send(300, 1'b0);
        send(400, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", sdata(), 0);
        check("arst_count", int'(out_count), 0);
        check("arst_ovf", int'(out_overflow), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(100, 1'b0);
        send(-40, 1'b0);
        send(7, 1'b1);
        expect_result("arst_rec", 67, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
